// File: rtl/psum_accum_sched_pkg.sv
// Shared types and defaults for the partial-sum accumulation scheduler.
// Holds the FSM state encoding and the default datapath/counter widths.
package psum_accum_sched_pkg;

    localparam int DATA_BITWIDTH_DEF = 16;
    localparam int BEAT_CNT_W_DEF    = 8;

    localparam logic [1:0] ST_IDLE_ENC  = 2'd0;
    localparam logic [1:0] ST_ACCUM_ENC = 2'd1;
    localparam logic [1:0] ST_DONE_ENC  = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE_ENC,
        ACCUM = ST_ACCUM_ENC,
        DONE  = ST_DONE_ENC
    } state_t;

endpackage

// File: rtl/psum_accum_sched_if.sv
// Streaming bus between the PE-array psum lanes, the scheduler and the
// output buffer write port.
interface psum_accum_sched_if
    import psum_accum_sched_pkg::*;
#(
    parameter int DATA_BITWIDTH = DATA_BITWIDTH_DEF
);
    logic                     in_valid;
    logic                     in_ready;
    logic [DATA_BITWIDTH-1:0] in_psum0;
    logic [DATA_BITWIDTH-1:0] in_psum1;
    logic                     out_valid;
    logic                     out_ready;
    logic [DATA_BITWIDTH-1:0] out_sum;

    // Environment side: feeds psums, consumes the result.
    modport master (
        output in_valid, in_psum0, in_psum1, out_ready,
        input  in_ready, out_valid, out_sum
    );

    // Scheduler side.
    modport slave (
        input  in_valid, in_psum0, in_psum1, out_ready,
        output in_ready, out_valid, out_sum
    );
endinterface

// File: rtl/psum_accum_sched_adder3.sv
// Three-operand modular adder shared by every accumulation beat.
module adder3 #(
    parameter int DATA_BITWIDTH = 16
) (
    input  logic [DATA_BITWIDTH-1:0] a,
    input  logic [DATA_BITWIDTH-1:0] b,
    input  logic [DATA_BITWIDTH-1:0] c,
    output logic [DATA_BITWIDTH-1:0] sum
);
    assign sum = a + b + c;
endmodule

// File: rtl/psum_accum_sched.sv
// Reduces a job of two-lane partial-sum beats into one accumulated result,
// one beat per cycle, through a single shared three-input adder.
module psum_accum_sched
    import psum_accum_sched_pkg::*;
#(
    parameter int DATA_BITWIDTH = DATA_BITWIDTH_DEF,
    parameter int BEAT_CNT_W    = BEAT_CNT_W_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [BEAT_CNT_W-1:0]    cfg_beats,
    input  logic [DATA_BITWIDTH-1:0] cfg_bias,
    input  logic [1:0]               cfg_lane_en,
    input  logic                     abort,
    psum_accum_sched_if.slave        bus,
    output logic                     busy,
    output logic [BEAT_CNT_W-1:0]    beats_done
);
    state_t                   state_reg, state_next;
    logic [DATA_BITWIDTH-1:0] acc_reg, acc_next;
    logic [DATA_BITWIDTH-1:0] out_sum_reg, out_sum_next;
    logic [BEAT_CNT_W-1:0]    beats_done_reg, beats_done_next;
    logic [BEAT_CNT_W-1:0]    cfg_beats_reg, cfg_beats_next;
    logic [1:0]               lane_en_reg, lane_en_next;
    logic [DATA_BITWIDTH-1:0] lane0_masked, lane1_masked, sum;
    logic                     in_ready_c, out_valid_c;

    assign lane0_masked = bus.in_psum0 & {DATA_BITWIDTH{lane_en_reg[0]}};
    assign lane1_masked = bus.in_psum1 & {DATA_BITWIDTH{lane_en_reg[1]}};

    adder3 #(.DATA_BITWIDTH(DATA_BITWIDTH)) u_adder3 (
        .a   (acc_reg),
        .b   (lane0_masked),
        .c   (lane1_masked),
        .sum (sum)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            acc_reg        <= '0;
            out_sum_reg    <= '0;
            beats_done_reg <= '0;
            cfg_beats_reg  <= '0;
            lane_en_reg    <= '0;
        end else begin
            state_reg      <= state_next;
            acc_reg        <= acc_next;
            out_sum_reg    <= out_sum_next;
            beats_done_reg <= beats_done_next;
            cfg_beats_reg  <= cfg_beats_next;
            lane_en_reg    <= lane_en_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        acc_next        = acc_reg;
        out_sum_next    = out_sum_reg;
        beats_done_next = beats_done_reg;
        cfg_beats_next  = cfg_beats_reg;
        lane_en_next    = lane_en_reg;
        in_ready_c      = 1'b0;
        out_valid_c     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start && !abort) begin
                    cfg_beats_next  = cfg_beats;
                    lane_en_next    = cfg_lane_en;
                    acc_next        = cfg_bias;
                    beats_done_next = '0;
                    if (cfg_beats == '0) begin
                        out_sum_next = cfg_bias;
                        state_next   = DONE;
                    end else begin
                        state_next = ACCUM;
                    end
                end
            end
            ACCUM: begin
                in_ready_c = 1'b1;
                // Abort beats a coincident last beat: nothing is committed.
                if (abort) begin
                    state_next = IDLE;
                end else if (bus.in_valid) begin
                    acc_next        = sum;
                    beats_done_next = beats_done_reg + BEAT_CNT_W'(1);
                    if (beats_done_next == cfg_beats_reg) begin
                        out_sum_next = sum;
                        state_next   = DONE;
                    end
                end
            end
            DONE: begin
                out_valid_c = 1'b1;
                if (bus.out_ready || abort) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_c;
    assign bus.out_sum   = out_sum_reg;
    assign busy          = (state_reg != IDLE);
    assign beats_done    = beats_done_reg;
endmodule

// File: tb/tb_psum_accum_sched.sv
// Directed and randomized jobs for psum_accum_sched, checked against a
// plain-arithmetic reduction model.
module tb_psum_accum_sched;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [7:0]  cfg_beats;
    logic [15:0] cfg_bias;
    logic [1:0]  cfg_lane_en;
    logic        abort;
    logic        busy;
    logic [7:0]  beats_done;

    int checks = 0;
    int failures = 0;
    logic [15:0] bq0[$];
    logic [15:0] bq1[$];

    psum_accum_sched_if #(.DATA_BITWIDTH(16)) bus ();

    psum_accum_sched #(.DATA_BITWIDTH(16), .BEAT_CNT_W(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .cfg_beats   (cfg_beats),
        .cfg_bias    (cfg_bias),
        .cfg_lane_en (cfg_lane_en),
        .abort       (abort),
        .bus         (bus),
        .busy        (busy),
        .beats_done  (beats_done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Model: result = bias + sum of enabled lanes, modulo 2^16.
    function automatic logic [15:0] model_sum(input logic [15:0] bias, input int nb,
                                              input logic [1:0] le);
        int unsigned total;
        total = bias;
        for (int i = 0; i < nb; i++) begin
            if (le[0]) total += bq0[i];
            if (le[1]) total += bq1[i];
        end
        return total[15:0];
    endfunction

    task automatic run_job(input logic [15:0] bias, input logic [7:0] nb, input logic [1:0] le,
                           input int gap, input int hold, input bit poke_start);
        logic [15:0] exp_sum;
        exp_sum = model_sum(bias, int'(nb), le);
        cfg_bias = bias; cfg_beats = nb; cfg_lane_en = le; start = 1'b1;
        tick();
        start = 1'b0;
        cfg_bias = 16'($urandom); cfg_beats = 8'($urandom); cfg_lane_en = 2'($urandom);
        if (nb == 8'd0) begin
            check("zero_valid", bus.out_valid, 1);
            check("zero_sum", bus.out_sum, exp_sum);
        end else begin
            check("accum_ready", bus.in_ready, 1);
            check("accum_busy", busy, 1);
            for (int i = 0; i < int'(nb); i++) begin
                repeat (gap) begin
                    tick();
                    check("gap_valid", bus.out_valid, 0);
                end
                bus.in_valid = 1'b1; bus.in_psum0 = bq0[i]; bus.in_psum1 = bq1[i];
                tick();
                bus.in_valid = 1'b0; bus.in_psum0 = 16'($urandom); bus.in_psum1 = 16'($urandom);
                if (i < int'(nb) - 1) check("mid_valid", bus.out_valid, 0);
                check("beats_done", beats_done, i + 1);
            end
            check("done_valid", bus.out_valid, 1);
            check("done_sum", bus.out_sum, exp_sum);
        end
        for (int c = 0; c < hold; c++) begin
            if (poke_start && c == 2) begin
                start = 1'b1; cfg_beats = 8'd0; cfg_bias = 16'd99;
            end
            tick();
            start = 1'b0;
            check("hold_valid", bus.out_valid, 1);
            check("hold_sum", bus.out_sum, exp_sum);
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check("release_valid", bus.out_valid, 0);
        check("release_busy", busy, 0);
        check("release_sum", bus.out_sum, exp_sum);
        tick();
        check("stay_idle", busy, 0);
        $display("job bias=%h beats=%0d lane_en=%b expected_sum=%h", bias, nb, le, exp_sum);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b1; abort = 1'b0;
        cfg_beats = 8'd2; cfg_bias = 16'd5; cfg_lane_en = 2'b11;
        bus.in_valid = 1'b0; bus.in_psum0 = '0; bus.in_psum1 = '0; bus.out_ready = 1'b0;

        for (int c = 0; c < 3; c++) begin
            tick();
            check("rst_out_valid", bus.out_valid, 0);
            check("rst_in_ready", bus.in_ready, 0);
            check("rst_busy", busy, 0);
            check("rst_out_sum", bus.out_sum, 0);
        end
        start = 1'b0; rst_n = 1'b1;
        tick();
        check("post_rst_busy", busy, 0);
        $display("reset held 3 cycles with start asserted");

        // Basic back-to-back job.
        bq0 = {16'd1, 16'd3, 16'd5}; bq1 = {16'd2, 16'd4, 16'd6};
        run_job(16'd10, 8'd3, 2'b11, 0, 0, 1'b0);
        check("basic_const", bus.out_sum, 16'd31);

        // Lane mask and valid gaps.
        bq0 = {16'd7, 16'd8}; bq1 = {16'd100, 16'd100};
        run_job(16'd0, 8'd2, 2'b01, 2, 0, 1'b0);
        check("mask_const", bus.out_sum, 16'd15);

        // Backpressure with a start pulse while busy.
        bq0 = {16'd20, 16'd30}; bq1 = {16'd1, 16'd2};
        run_job(16'd3, 8'd2, 2'b10, 0, 5, 1'b1);

        // Wrap-around, then a zero-length job.
        bq0 = {16'd1}; bq1 = {16'd1};
        run_job(16'hFFFF, 8'd1, 2'b11, 0, 0, 1'b0);
        check("wrap_const", bus.out_sum, 16'h0001);
        run_job(16'd42, 8'd0, 2'b11, 0, 1, 1'b0);

        // Abort coincident with the last-beat accept.
        cfg_bias = 16'd1; cfg_beats = 8'd2; cfg_lane_en = 2'b11; start = 1'b1;
        tick();
        start = 1'b0;
        bus.in_valid = 1'b1; bus.in_psum0 = 16'd4; bus.in_psum1 = 16'd4;
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0; bus.in_valid = 1'b0;
        check("abort_valid", bus.out_valid, 0);
        check("abort_busy", busy, 0);
        check("abort_ready", bus.in_ready, 0);
        repeat (3) begin
            tick();
            check("abort_no_result", bus.out_valid, 0);
        end
        $display("abort on last beat");

        // Abort together with start in IDLE drops the start.
        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        check("abort_start_busy", busy, 0);
        $display("abort with start in idle");

        // Reset mid-ACCUM.
        cfg_bias = 16'd77; cfg_beats = 8'd4; cfg_lane_en = 2'b11; start = 1'b1;
        tick();
        start = 1'b0;
        bus.in_valid = 1'b1; bus.in_psum0 = 16'd9; bus.in_psum1 = 16'd9;
        tick();
        bus.in_valid = 1'b0; rst_n = 1'b0;
        tick();
        check("midrst_valid", bus.out_valid, 0);
        check("midrst_ready", bus.in_ready, 0);
        check("midrst_busy", busy, 0);
        check("midrst_sum", bus.out_sum, 0);
        check("midrst_beats", beats_done, 0);
        rst_n = 1'b1;
        tick();
        $display("reset during accumulation");

        // Randomized jobs.
        for (int j = 0; j < 8; j++) begin
            int nb;
            nb = int'($urandom_range(1, 6));
            bq0.delete(); bq1.delete();
            for (int i = 0; i < nb; i++) begin
                bq0.push_back(16'($urandom));
                bq1.push_back(16'($urandom));
            end
            run_job(16'($urandom), 8'(nb), 2'($urandom), int'($urandom_range(0, 2)),
                    int'($urandom_range(0, 3)), 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/psum_accum_sched.md
Name: psum_accum_sched

Overview:
- Scheduler that time-multiplexes one three-input adder (adder3) to reduce a stream of two-lane partial sums into one accumulated result.
- Each accepted beat computes acc <= acc + lane0 + lane1.
- Sits between the PE-array psum output lanes and the output buffer write port.
- Sequences one reduction job per start pulse, using valid/ready handshakes on both sides.

Parameters:
- DATA_BITWIDTH, 16: width of the psum lanes, accumulator and result.
- BEAT_CNT_W, 8: width of the beat-count config; maximum job length is 2^BEAT_CNT_W-1 beats.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst_n  input  1  synchronous, active-low reset.
- start  input  1  one-cycle job-start pulse; accepted only in IDLE.
- cfg_beats  input  BEAT_CNT_W  number of input beats in the job; sampled on accepted start.
- cfg_bias  input  DATA_BITWIDTH  initial accumulator value; sampled on accepted start.
- cfg_lane_en  input  2  lane enables; bit0=lane0, bit1=lane1. A disabled lane contributes 0. Sampled on accepted start.
- abort  input  1  synchronous job cancel.
- in_valid  input  1  input beat valid.
- in_ready  output  1  scheduler can accept a beat.
- in_psum0  input  DATA_BITWIDTH  lane-0 partial sum.
- in_psum1  input  DATA_BITWIDTH  lane-1 partial sum.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts the result.
- out_sum  output  DATA_BITWIDTH  accumulated result.
- busy  output  1  high whenever state is not IDLE.
- beats_done  output  BEAT_CNT_W  beats accepted in the current job.

Behaviour:
- Reset: rst_n is synchronous and active-low.
  - While rst_n=0 at a clock edge: state<=IDLE; acc, beats_done, out_sum <= 0.
  - out_valid=0, in_ready=0, busy=0.
  - Reset overrides start and abort, and can occur mid-job; the partial job is discarded.
- States: IDLE, ACCUM, DONE.
- IDLE:
  - in_ready=0, out_valid=0.
  - On start: latch cfg_beats, cfg_lane_en; acc<=cfg_bias; beats_done<=0.
  - If cfg_beats==0: go to DONE with out_sum<=cfg_bias. Otherwise go to ACCUM.
- ACCUM:
  - in_ready=1, driven combinationally from state only (no dependence on in_valid).
  - Beat accepted when in_valid & in_ready.
  - On accept: sum = adder3(acc, in_psum0 & {DATA_BITWIDTH{lane_en[0]}}, in_psum1 & {DATA_BITWIDTH{lane_en[1]}}); acc<=sum; beats_done<=beats_done+1.
  - On the accepted beat where beats_done+1 == latched cfg_beats: out_sum<=sum; go to DONE.
  - No bubble is required between beats: one beat per cycle.
- DONE:
  - out_valid=1; out_sum held stable until the handshake.
  - On out_ready: go to IDLE next cycle; out_valid drops. out_sum keeps its value.
- Latency: last beat accepted at edge t gives out_valid=1 in the cycle after t. A zero-beat job gives out_valid one cycle after start.
- start while busy: ignored. It is not queued and there is no error flag.
- abort:
  - In ACCUM or DONE: go to IDLE next cycle. No result is emitted; out_valid drops; acc is not cleared.
  - abort in the same cycle as the last-beat accept: abort wins.
  - abort in the same cycle as the out_ready handshake in DONE: the result counts as delivered, and the state goes to IDLE.
  - abort in IDLE, including in the same cycle as start: the start is dropped.
- Arithmetic: modulo 2^DATA_BITWIDTH wrap-around. No saturation and no overflow flag.
- cfg_* changes after start have no effect on the running job.

Decomposition:
- Shared package:
  - State encoding localparams: IDLE=2'd0, ACCUM=2'd1, DONE=2'd2.
  - Default DATA_BITWIDTH and BEAT_CNT_W constants.
- Sub-module: one instance of the existing adder3 (DATA_BITWIDTH passed through) provides the datapath sum.
- FSM, counters and lane masking live in psum_accum_sched.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with start=1 -> out_valid=0, in_ready=0, busy=0, out_sum=0 throughout; remains IDLE.
- Basic job: bias=10, beats=3, lane_en=2'b11, back-to-back beats (1,2),(3,4),(5,6) -> out_valid one cycle after the 3rd accept, out_sum=31, beats_done=3; idle after the out_ready handshake.
- Lane mask and in_valid gaps: bias=0, beats=2, lane_en=2'b01, beats (7,100) and (8,100) with 2 idle cycles between -> out_sum=15.
- Backpressure and ignored start: out_ready=0 for 5 cycles in DONE, pulse start at cycle 2 -> out_sum stable; out_valid held; no second job; busy drops after out_ready.
- Wrap-around and zero length: bias=16'hFFFF, beats=1, beat (1,1) -> out_sum=16'h0001. Then beats=0, bias=42 -> out_sum=42 one cycle after start.
- Abort and mid-job reset:
  - abort coincident with the last beat accept -> out_valid never asserts; IDLE next cycle.
  - rst_n=0 mid-ACCUM -> all outputs reset values.
  - A new job afterwards yields a correct sum.
